qencoder_speed: RTL and testbench
=================================

Name: qencoder_speed

Overview:
- Downstream stage of the quadrature encoder counter. Consumes its free-running position count and produces a signed speed estimate.
- Method: fixed gate-time. Speed is the position delta accumulated over a programmable window of clock cycles.
- Also flags saturation and motor stall.
- Intended to sit next to the counter in the top level, with its outputs exposed to the VIO for debug.

Parameters:
- NB, 32, width of input position count (two's-complement wrap counter)
- NS, 16, width of signed speed output (NS <= NB)
- NW, 24, width of runtime window-length input
- STALL_N, 4, consecutive zero-delta windows before o_stall asserts (>= 1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- i_reset  input  1  asynchronous, active-high reset
- i_enable  input  1  measurement enable (level)
- i_position  input  NB  position count from encoder counter, synchronous to clk
- i_window  input  NW  window length in clk cycles; 0 treated as 1
- o_speed  output  NS  signed counts per window, saturated
- o_valid  output  1  one-cycle pulse when o_speed/o_sat updated
- o_sat  output  1  registered with o_valid: this window's delta was clipped
- o_stall  output  1  level: STALL_N consecutive zero-delta windows seen

Behaviour:
- Reset (async assert, sync-released by the clock domain):
  - State IDLE; window counter = 0; baseline = 0; stall counter = 0.
  - o_speed = 0, o_valid = 0, o_sat = 0, o_stall = 0.
  - Reset mid-window discards the partial window; no o_valid is produced.
- States:
  - IDLE -> RUN when i_enable = 1. In that same edge: baseline <= i_position, counter <= 0, effective window W <= max(i_window, 1).
  - RUN -> IDLE on the edge where i_enable = 0. Partial window is discarded, no o_valid is produced, o_speed holds its last value, o_stall and the stall counter clear.
- Window timing in RUN:
  - Counter increments every cycle.
  - Terminal cycle is counter == W-1. On that edge: delta = i_position - baseline (NB-bit modulo subtraction); baseline <= i_position; counter <= 0; W re-sampled from i_window.
  - i_window changes take effect only at window boundaries.
- Output timing:
  - o_speed, o_sat and o_valid are registered one cycle after the terminal edge.
  - First o_valid comes W+1 cycles after the IDLE->RUN edge; subsequent pulses are every W cycles.
  - o_valid is high exactly one cycle per window. With W = 1 it is high every cycle.
- Arithmetic:
  - Wrap-around of i_position is handled by modulo subtraction: delta is correct whenever |true delta| < 2^(NB-1).
  - If delta > 2^(NS-1)-1: o_speed = 2^(NS-1)-1, o_sat = 1.
  - If delta < -2^(NS-1): o_speed = -2^(NS-1), o_sat = 1.
  - Otherwise o_speed = delta truncated to NS bits, o_sat = 0.
- Stall detection:
  - Each window with delta == 0 increments the stall counter, saturating at STALL_N.
  - Any nonzero delta clears the stall counter and o_stall, in the same cycle as that window's o_valid.
  - o_stall rises with the o_valid of the STALL_N-th consecutive zero window.
- Simultaneous events:
  - i_enable falling on the terminal cycle wins: no o_valid is produced for that window.
  - i_reset overrides everything.

Test Plan:
- Reset values: assert i_reset with i_enable = 1 and position changing -> all outputs 0; o_valid never pulses while i_reset is high.
- Basic rate: NB=32, NS=16, i_window=100; enable at t0 with position 0; position +1 every 10 cycles -> o_valid at t0+101 with o_speed = 10, then every 100 cycles with 10; o_sat = 0.
- Wrap and sign:
  - Baseline 0xFFFFFFFE, position 0x00000003 at the window end -> o_speed = +5.
  - Baseline 0x00000002, position 0xFFFFFFFD -> o_speed = -5.
- Saturation: delta +40000 -> o_speed = 32767, o_sat = 1. Delta -40000 -> o_speed = -32768, o_sat = 1. Next window with delta 7 -> o_speed = 7, o_sat = 0.
- Stall: STALL_N = 4, position constant -> o_stall rises with the 4th o_valid; a window with delta 1 -> o_stall = 0 with that o_valid.
- Mid-window abort:
  - Drop i_enable at counter = 50 (W = 100) -> no o_valid, o_speed holds its prior value.
  - Re-enable -> new baseline, first o_valid 101 cycles later.
  - Change i_window from 100 to 20 mid-window -> current window stays 100, next window is 20.

Source files
------------

// File: rtl/qencoder_speed.sv
// qencoder_speed: fixed gate-time speed estimator with saturation and stall detection
module qencoder_speed #(
   parameter int NB      = 32,
   parameter int NS      = 16,
   parameter int NW      = 24,
   parameter int STALL_N = 4
) (
   input  logic                 clk,
   input  logic                 i_reset,
   input  logic                 i_enable,
   input  logic [NB-1:0]        i_position,
   input  logic [NW-1:0]        i_window,
   output logic signed [NS-1:0] o_speed,
   output logic                 o_valid,
   output logic                 o_sat,
   output logic                 o_stall
);
   localparam int SW = $clog2(STALL_N + 1);
   localparam logic [SW-1:0] STALL_MAX = SW'(STALL_N);
   localparam logic signed [NB-1:0] SMAX = {{(NB-NS+1){1'b0}}, {(NS-1){1'b1}}};
   localparam logic signed [NB-1:0] SMIN = {{(NB-NS+1){1'b1}}, {(NS-1){1'b0}}};
   typedef enum logic {IDLE, RUN} state_t;
   state_t               state;
   logic [NW-1:0]        cnt, win, win_eff;
   logic [NB-1:0]        base;
   logic signed [NB-1:0] delta, delta_r;
   logic                 pend, term, hi, lo;
   logic [SW-1:0]        stall_cnt;
   assign win_eff = (i_window == '0) ? NW'(1) : i_window;
   assign delta   = i_position - base;
   assign term    = cnt == win - NW'(1);
   assign hi      = delta_r > SMAX;
   assign lo      = delta_r < SMIN;
   // window sequencing, delta capture one edge, clipped outputs and stall tracking the next
   always_ff @(posedge clk or posedge i_reset) begin
      if (i_reset) begin
         state     <= IDLE;
         cnt       <= '0;
         win       <= '0;
         base      <= '0;
         delta_r   <= '0;
         pend      <= 1'b0;
         stall_cnt <= '0;
         o_speed   <= '0;
         o_valid   <= 1'b0;
         o_sat     <= 1'b0;
         o_stall   <= 1'b0;
      end else begin
         pend    <= 1'b0;
         o_valid <= pend;
         if (pend) begin
            o_speed <= hi ? SMAX[NS-1:0] : lo ? SMIN[NS-1:0] : delta_r[NS-1:0];
            o_sat   <= hi || lo;
            if (delta_r == '0) begin
               stall_cnt <= (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + 1'b1;
               o_stall   <= stall_cnt >= STALL_MAX - 1'b1;
            end else begin
               stall_cnt <= '0;
               o_stall   <= 1'b0;
            end
         end
         if (state == IDLE) begin
            if (i_enable) begin
               state <= RUN;
               base  <= i_position;
               cnt   <= '0;
               win   <= win_eff;
            end
         end else if (!i_enable) begin
            state     <= IDLE;
            stall_cnt <= '0;
            o_stall   <= 1'b0;
         end else if (term) begin
            base    <= i_position;
            cnt     <= '0;
            win     <= win_eff;
            delta_r <= delta;
            pend    <= 1'b1;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_qencoder_speed.sv
// tb_qencoder_speed: directed vector table plus hand sequences for the speed estimator
module tb_qencoder_speed;
   localparam int NB = 32, NS = 16, NW = 24, STALL_N = 4;
   logic clk = 1'b0;
   logic i_reset, i_enable;
   logic [NB-1:0] i_position;
   logic [NW-1:0] i_window;
   logic signed [NS-1:0] o_speed;
   logic o_valid, o_sat, o_stall;
   int n_run = 0, n_fail = 0;
   typedef struct {
      logic [NB-1:0] base;
      logic [NB-1:0] fin;
      logic [NW-1:0] win;
      int            spd;
      bit            sat;
   } vec_t;
   vec_t v[13];
   always #5 clk = ~clk;
   qencoder_speed #(.NB(NB), .NS(NS), .NW(NW), .STALL_N(STALL_N)) dut (
      .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_position(i_position),
      .i_window(i_window), .o_speed(o_speed), .o_valid(o_valid), .o_sat(o_sat), .o_stall(o_stall)
   );
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_run++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask
   initial begin
      int nv, first, second, w;
      bit early;
      v[0]  = '{32'd0,          32'd10,         24'd4, 10,     1'b0};
      v[1]  = '{32'hFFFFFFFE,   32'h00000003,   24'd3, 5,      1'b0};
      v[2]  = '{32'h00000002,   32'hFFFFFFFD,   24'd5, -5,     1'b0};
      v[3]  = '{32'd0,          32'd40000,      24'd4, 32767,  1'b1};
      v[4]  = '{32'd40000,      32'd0,          24'd4, -32768, 1'b1};
      v[5]  = '{32'd100,        32'd107,        24'd4, 7,      1'b0};
      v[6]  = '{32'd0,          32'd32767,      24'd2, 32767,  1'b0};
      v[7]  = '{32'd0,          32'd32768,      24'd2, 32767,  1'b1};
      v[8]  = '{32'd32768,      32'd0,          24'd2, -32768, 1'b0};
      v[9]  = '{32'd32769,      32'd0,          24'd2, -32768, 1'b1};
      v[10] = '{32'h7FFFFFFF,   32'h80000000,   24'd3, 1,      1'b0};
      v[11] = '{32'd0,          32'd0,          24'd3, 0,      1'b0};
      v[12] = '{32'd5,          32'd9,          24'd0, 4,      1'b0};
      // reset held with enable high and moving position
      i_reset = 1'b1; i_enable = 1'b1; i_window = 24'd1; i_position = '0;
      nv = 0;
      for (int k = 0; k < 8; k++) begin
         i_position = NB'(k * 3);
         tick();
         nv += int'(o_valid);
      end
      chk("rst_no_valid", nv, 0);
      chk("rst_speed", $signed(o_speed), 0);
      chk("rst_sat", o_sat, 0);
      chk("rst_stall", o_stall, 0);
      i_enable = 1'b0;
      i_reset = 1'b0;
      tick();
      // vector table: one window per record
      for (int i = 0; i < 13; i++) begin
         i_position = v[i].base; i_window = v[i].win; i_enable = 1'b1;
         tick();
         i_position = v[i].fin;
         w = (v[i].win == '0) ? 1 : int'(v[i].win);
         early = 1'b0;
         repeat (w) begin
            tick();
            if (o_valid) early = 1'b1;
         end
         chk($sformatf("v%0d_early", i), early, 0);
         tick();
         chk($sformatf("v%0d_valid", i), o_valid, 1);
         chk($sformatf("v%0d_speed", i), $signed(o_speed), v[i].spd);
         chk($sformatf("v%0d_sat", i), o_sat, v[i].sat);
         i_enable = 1'b0;
         tick();
      end
      // asynchronous reset mid-window
      i_window = 24'd4; i_position = '0; i_enable = 1'b1;
      tick();
      i_position = 32'd50;
      tick(); tick();
      #2 i_reset = 1'b1;
      #1 chk("async_rst_speed", $signed(o_speed), 0);
      nv = 0;
      repeat (6) begin tick(); nv += int'(o_valid); end
      chk("async_rst_no_valid", nv, 0);
      i_enable = 1'b0;
      i_reset = 1'b0;
      tick();
      // basic rate: W=100, +1 count every 10 cycles
      i_window = 24'd100; i_position = '0; i_enable = 1'b1;
      tick();
      nv = 0; first = 0; second = 0;
      for (int k = 1; k <= 250; k++) begin
         i_position = NB'(k / 10);
         tick();
         if (o_valid) begin
            nv++;
            if (nv == 1) first = k;
            if (nv == 2) second = k;
            chk($sformatf("rate_speed%0d", nv), $signed(o_speed), 10);
            chk($sformatf("rate_sat%0d", nv), o_sat, 0);
         end
      end
      chk("rate_count", nv, 2);
      chk("rate_first", first, 101);
      chk("rate_second", second, 201);
      i_enable = 1'b0;
      tick();
      // stall rises with W=1, then clears on disable
      i_window = 24'd1; i_position = 32'h55; i_enable = 1'b1;
      tick();
      repeat (5) tick();
      chk("stall_w1_set", o_stall, 1);
      i_enable = 1'b0;
      tick();
      chk("stall_disable_clr", o_stall, 0);
      // stall on 4th zero window, cleared by a delta-1 window
      i_window = 24'd4; i_position = 32'h1234; i_enable = 1'b1;
      tick();
      nv = 0;
      for (int k = 0; k < 40 && nv < 5; k++) begin
         tick();
         if (o_valid) begin
            nv++;
            chk($sformatf("stall_n%0d", nv), o_stall, nv == 4);
            if (nv == 4) i_position = 32'h1235;
            if (nv == 5) chk("stall_clr_speed", $signed(o_speed), 1);
         end
      end
      chk("stall_windows", nv, 5);
      i_enable = 1'b0;
      tick();
      // abort at counter 50: no output, speed holds
      i_window = 24'd100; i_position = '0; i_enable = 1'b1;
      tick();
      i_position = 32'd77;
      nv = 0;
      repeat (50) begin tick(); nv += int'(o_valid); end
      i_enable = 1'b0;
      repeat (80) begin tick(); nv += int'(o_valid); end
      chk("abort_no_valid", nv, 0);
      chk("abort_hold", $signed(o_speed), 1);
      // re-enable, window shortened mid-window takes effect next window
      i_position = 32'd1000; i_enable = 1'b1;
      tick();
      i_position = 32'd1003;
      first = 0; second = 0;
      for (int k = 1; k <= 140; k++) begin
         if (k == 30) i_window = 24'd20;
         tick();
         if (o_valid) begin
            if (first == 0) begin
               first = k;
               chk("reen_speed", $signed(o_speed), 3);
               i_position = 32'd1010;
            end else if (second == 0) begin
               second = k;
               chk("win20_speed", $signed(o_speed), 7);
            end
         end
      end
      chk("reen_first", first, 101);
      chk("win20_second", second, 121);
      i_enable = 1'b0;
      tick();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
